// File: rtl/mtrx_slice_streamer_pkg.sv
// Shared widths, types and FSM encoding for the slice streamer and its skid buffer.
package mtrx_slice_streamer_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 512;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mtrx_slice_streamer_if.sv
// Element stream towards the spiking-matmul array (valid/ready with a last marker).
interface mtrx_slice_streamer_if;
  import mtrx_slice_streamer_pkg::*;

  logic  m_valid;
  logic  m_ready;
  elem_t m_data;
  logic  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/mtrx_slice_streamer_skid.sv
// Two-entry register FIFO that absorbs FIFO read data while the stream is stalled.
module mtrx_slice_streamer_skid
  import mtrx_slice_streamer_pkg::*;
(
  input  logic       s_clk,
  input  logic       s_rst_n,
  input  logic       push_i,
  input  elem_t      din_i,
  input  logic       pop_i,
  output elem_t      head_o,
  output logic [1:0] cnt_o
);

  elem_t      entry_q [2];
  elem_t      entry_d [2];
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q != 2'd2) begin
          entry_d[cnt_q[0]] = din_i;
          cnt_d             = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        entry_d[0] = entry_q[1];
        cnt_d      = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new element lands behind the survivor.
        if (cnt_q == 2'd1) begin
          entry_d[0] = din_i;
        end else if (cnt_q == 2'd2) begin
          entry_d[0] = entry_q[1];
          entry_d[1] = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      cnt_q      <= 2'd0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_o = entry_q[0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mtrx_slice_streamer.sv
// Pops a slice of elements from the slice FIFO and replays it as a valid/ready stream
// with m_last on the final element and a one-cycle done pulse.
module mtrx_slice_streamer
  import mtrx_slice_streamer_pkg::*;
(
  input  logic  s_clk,
  input  logic  s_rst_n,
  input  logic  start,
  input  len_t  slice_len,
  input  logic  fifo_empty,
  output logic  fifo_rd_en,
  input  elem_t fifo_dout,
  output logic  busy,
  output logic  done,
  mtrx_slice_streamer_if.master m_if
);

  state_e     state_q, state_d;
  len_t       issued_q, issued_d;
  len_t       sent_q, sent_d;
  len_t       len_q, len_d;
  logic       inflight_q;
  logic [1:0] buf_cnt;
  elem_t      buf_head;
  logic       start_acc;
  logic       xfer;
  logic       last_elem;
  logic [1:0] occupancy;

  assign start_acc = start && (state_q == ST_IDLE);
  assign xfer      = m_if.m_valid && m_if.m_ready;
  assign last_elem = (sent_q == len_q - len_t'(1));
  // An element leaving this cycle frees a slot, which is what sustains one element per cycle.
  assign occupancy = {1'b0, inflight_q} + buf_cnt - {1'b0, xfer};

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_acc) state_d = (slice_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issued_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (xfer && last_elem) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && (issued_q < len_q)
                 && (occupancy < 2'd2);
  end

  always_comb begin
    issued_d = issued_q;
    sent_d   = sent_q;
    len_d    = len_q;
    if (start_acc) begin
      issued_d = '0;
      sent_d   = '0;
      len_d    = slice_len;
    end else begin
      if (fifo_rd_en) issued_d = issued_q + len_t'(1);
      if (xfer)       sent_d   = sent_q + len_t'(1);
    end
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      issued_q   <= '0;
      sent_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      len_q      <= len_d;
      inflight_q <= fifo_rd_en;
    end
  end

  mtrx_slice_streamer_skid u_skid (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .push_i  (inflight_q),
    .din_i   (fifo_dout),
    .pop_i   (xfer),
    .head_o  (buf_head),
    .cnt_o   (buf_cnt)
  );

  assign m_if.m_valid = (buf_cnt != 2'd0);
  assign m_if.m_data  = buf_head;
  assign m_if.m_last  = m_if.m_valid && last_elem;

endmodule
